aes_key_sched_ctrl: RTL

- Iterative AES key-schedule controller: accepts a cipher key and expands it into the full FIPS-197 word array w[0..4*Nr+3], one 32-bit word per clock.
- Stores all round keys and serves any 128-bit round key through a random-access read port to the round datapath.
- Replaces the fully combinational key expansion wherever area matters. Sits between the key-load interface and the cipher round sequencer.

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_key_sched_ctrl_if.sv | 22 ++
 rtl/aes_subword.sv | 9 +
 rtl/aes_key_sched_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers for the iterative key schedule: S-box, xtime, RotWord,
// the Rcon seed, the key-state encoding and the legal Nk/Nr pairs.
package aes_pkg;

    localparam int NK_128 = 4;
    localparam int NR_128 = 10;
    localparam int NK_192 = 6;
    localparam int NR_192 = 12;
    localparam int NK_256 = 8;
    localparam int NR_256 = 14;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } ks_state_t;

    // Forward S-box, entry 0 in bits 0:7 (ascending range keeps table order readable).
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic legal_pair(input int nk, input int nr);
        return (nk == NK_128 && nr == NR_128) ||
               (nk == NK_192 && nr == NR_192) ||
               (nk == NK_256 && nr == NR_256);
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Key-load handshake, status and round-key read port of the key scheduler.
interface aes_key_sched_ctrl_if #(
    parameter int Nkb = 128
) ();
    logic             key_valid;
    logic             key_ready;
    logic [0:Nkb-1]   key;
    logic             busy;
    logic             keys_valid;
    logic [3:0]       rk_idx;
    logic [0:127]     rk;

    modport master (
        output key_valid, key, rk_idx,
        input  key_ready, busy, keys_valid, rk
    );

    modport slave (
        input  key_valid, key, rk_idx,
        output key_ready, busy, keys_valid, rk
    );
endinterface

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] din,
    output logic [31:0] dout
);
    assign dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key expansion, one word per clock, with a random-access
// round-key read port that only exposes a completely expanded schedule.
//
// state  | meaning
// IDLE   | no schedule yet, waiting for a key
// EXPAND | generating w[Nk..NW-1], one word per cycle
// DONE   | schedule complete and served on rk; a new key restarts expansion
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    aes_key_sched_ctrl_if.slave  bus
);
    localparam int         Nkb     = Nk * 32;
    localparam int         NW      = 4 * Nr + 4;
    localparam logic [5:0] NK_W    = 6'(Nk);
    localparam logic [5:0] NW_W    = 6'(NW);
    localparam logic [3:0] NR_W    = 4'(Nr);
    localparam logic [2:0] PH_LAST = 3'(Nk - 1);

    ks_state_t    state, state_nxt;
    logic         accept, wr_en;
    logic [31:0]  w [NW];
    logic [5:0]   i;
    logic [2:0]   phase;
    logic [7:0]   rcon;
    logic [31:0]  w_prev, w_back, sub_in, sub_out, temp, w_new;
    logic [5:0]   base;
    logic [0:127] rk_sel;

    // State register; reset aborts any expansion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus key-accept and word-write strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.key_valid) begin
                    accept    = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                // i reaching NW means the last word landed on the previous edge.
                if (i == NW_W) state_nxt = DONE;
                else           wr_en     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.key_ready  = (state != EXPAND);
    assign bus.busy       = (state == EXPAND);
    assign bus.keys_valid = (state == DONE);

    assign w_prev = w[i - 6'd1];
    assign w_back = w[i - NK_W];
    assign sub_in = (phase == 3'd0) ? rot_word(w_prev) : w_prev;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    // Select the temp word for this step of the recurrence.
    always_comb begin
        temp = w_prev;
        if (phase == 3'd0)                temp = sub_out ^ {rcon, 24'h0};
        else if (Nk > 6 && phase == 3'd4) temp = sub_out;
    end

    assign w_new = w_back ^ temp;

    // Word index, mod-Nk phase and Rcon sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i     <= NK_W;
            phase <= 3'd0;
            rcon  <= RCON_INIT;
        end else if (accept) begin
            i     <= NK_W;
            phase <= 3'd0;
            rcon  <= RCON_INIT;
        end else if (wr_en) begin
            i     <= i + 6'd1;
            phase <= (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
            if (phase == 3'd0) rcon <= xtime(rcon);
        end
    end

    // Word storage: key words on accept, then one expanded word per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < Nk; j++) w[j] <= bus.key[j*32 +: 32];
        end else if (wr_en) begin
            w[i] <= w_new;
        end
    end

    assign base = {bus.rk_idx, 2'b00};

    // Round-key read mux, forced to zero unless the whole schedule is valid.
    always_comb begin
        rk_sel = '0;
        if (state == DONE && bus.rk_idx <= NR_W)
            rk_sel = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};
    end

    assign bus.rk = rk_sel;

    logic unused_nkb;
    assign unused_nkb = (Nkb == 0);
endmodule
